// File: rtl/aes128_key_schedule.sv
// AES-128 iterative key expansion: emits round keys 0..10 over a valid/ready
// stream, computing each next round key combinationally from the current one.

// Byte substitution: multiplicative inverse in GF(2^8) followed by the AES
// affine transform.
module aes_sbox (
    input  logic [7:0] sbox_in,
    output logic [7:0] sbox_out
);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // x^254 == x^-1 for nonzero x, and maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = x;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    logic [7:0] inv;

    // Inverse followed by affine map b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
    always_comb begin
        inv      = gf_inv(sbox_in);
        sbox_out = inv
                 ^ {inv[6:0], inv[7]}
                 ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]}
                 ^ {inv[3:0], inv[7:4]}
                 ^ 8'h63;
    end

endmodule

module aes128_key_schedule (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] key_in,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_round,
    output logic         rk_last
);

    typedef enum logic [0:0] {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    state_t         state_q, state_d;
    logic [127:0]   key_q, key_d;
    logic [3:0]     round_q, round_d;
    logic [7:0]     rcon_q, rcon_d;

    logic [31:0]    w0, w1, w2, w3;
    logic [31:0]    rot_w3, sub_w, t_w;
    logic [31:0]    n0, n1, n2, n3;
    logic           last_round;
    logic           rk_fire;

    assign w0 = key_q[127:96];
    assign w1 = key_q[95:64];
    assign w2 = key_q[63:32];
    assign w3 = key_q[31:0];

    assign rot_w3 = {w3[23:0], w3[31:24]};

    aes_sbox u_sbox0 (.sbox_in(rot_w3[31:24]), .sbox_out(sub_w[31:24]));
    aes_sbox u_sbox1 (.sbox_in(rot_w3[23:16]), .sbox_out(sub_w[23:16]));
    aes_sbox u_sbox2 (.sbox_in(rot_w3[15:8]),  .sbox_out(sub_w[15:8]));
    aes_sbox u_sbox3 (.sbox_in(rot_w3[7:0]),   .sbox_out(sub_w[7:0]));

    // Next round key: the chained XORs form the critical path into key_q.
    always_comb begin
        t_w = sub_w ^ {rcon_q, 24'h000000};
        n0  = w0 ^ t_w;
        n1  = w1 ^ n0;
        n2  = w2 ^ n1;
        n3  = w3 ^ n2;
    end

    assign last_round = (round_q == 4'd10);
    assign rk_fire    = (state_q == ACTIVE) && rk_ready;

    // State register plus key/round/rcon datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            round_q <= '0;
            rcon_q  <= 8'h01;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
        end
    end

    // Next-state: accept a key in IDLE, return to IDLE once round 10 is taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (key_valid) state_d = ACTIVE;
            ACTIVE:  if (rk_ready && last_round) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath update: load on accept, advance on every non-final handshake.
    always_comb begin
        key_d   = key_q;
        round_d = round_q;
        rcon_d  = rcon_q;
        if (state_q == IDLE) begin
            if (key_valid) begin
                key_d   = key_in;
                round_d = 4'd0;
                rcon_d  = 8'h01;
            end
        end else if (rk_fire && !last_round) begin
            key_d   = {n0, n1, n2, n3};
            round_d = round_q + 4'd1;
            rcon_d  = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
        end
    end

    // Outputs: handshake flags from state, data straight from the key register.
    always_comb begin
        key_ready = (state_q == IDLE);
        rk_valid  = (state_q == ACTIVE);
        rk_last   = (state_q == ACTIVE) && last_round;
        rk_data   = key_q;
        rk_round  = round_q;
    end

endmodule

// File: tb/tb_aes128_key_schedule.sv
// Directed bench for aes128_key_schedule using FIPS-197 key-expansion vectors.
module tb_aes128_key_schedule;

    logic         clk;
    logic         rst_n;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] key_in;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_data;
    logic [3:0]   rk_round;
    logic         rk_last;

    aes128_key_schedule dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_valid(key_valid),
        .key_ready(key_ready),
        .key_in   (key_in),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_data  (rk_data),
        .rk_round (rk_round),
        .rk_last  (rk_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] key;
        int           round;
        logic [127:0] exp;
    } vec_t;

    localparam logic [127:0] KEY_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_ZERO = 128'h0;

    vec_t         tbl [14];
    logic [127:0] got [0:10];
    int           checks;
    int           failures;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Offer a key at the current negedge; it is taken on the next posedge.
    task automatic accept_key(input logic [127:0] k, input bit hold);
        key_valid = 1'b1;
        key_in    = k;
        chk("key_ready_idle", {127'b0, key_ready}, 128'd1);
        @(negedge clk);
        if (!hold) key_valid = 1'b0;
        key_in = ~k;
    endtask

    // Consume rounds 0..10 from the current negedge, optionally with random stalls.
    task automatic collect(input bit stall);
        int           n;
        int           cyc;
        bit           rdy;
        bit           prev_stall;
        logic [127:0] prev_data;
        logic [3:0]   prev_round;
        n          = 0;
        cyc        = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_round = '0;
        while (n < 11 && cyc < 300) begin
            rdy      = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
            rk_ready = rdy;
            chk("rk_valid_active", {127'b0, rk_valid}, 128'd1);
            chk("key_ready_active", {127'b0, key_ready}, 128'd0);
            chk("rk_round", {124'b0, rk_round}, 128'(n));
            chk("rk_last", {127'b0, rk_last}, {127'b0, (n == 10)});
            if (prev_stall) begin
                chk("stall_data", rk_data, prev_data);
                chk("stall_round", {124'b0, rk_round}, {124'b0, prev_round});
            end
            if (rdy) got[n] = rk_data;
            prev_stall = !rdy;
            prev_data  = rk_data;
            prev_round = rk_round;
            @(negedge clk);
            if (rdy) n++;
            cyc++;
        end
        rk_ready = 1'b1;
        if (n < 11) chk("collect_timeout", 128'(n), 128'd11);
        chk("rk_valid_after_last", {127'b0, rk_valid}, 128'd0);
        chk("key_ready_after_last", {127'b0, key_ready}, 128'd1);
    endtask

    task automatic compare_table(input logic [127:0] k);
        for (int i = 0; i < 14; i++) begin
            if (tbl[i].key == k) chk($sformatf("round_key_%0d", tbl[i].round), got[tbl[i].round], tbl[i].exp);
        end
    endtask

    task automatic clear_got();
        for (int i = 0; i < 11; i++) got[i] = 'x;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        tbl[0]  = '{KEY_A1, 0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
        tbl[1]  = '{KEY_A1, 1,  128'ha0fafe1788542cb123a339392a6c7605};
        tbl[2]  = '{KEY_A1, 2,  128'hf2c295f27a96b9435935807a7359f67f};
        tbl[3]  = '{KEY_A1, 3,  128'h3d80477d4716fe3e1e237e446d7a883b};
        tbl[4]  = '{KEY_A1, 4,  128'hef44a541a8525b7fb671253bdb0bad00};
        tbl[5]  = '{KEY_A1, 5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
        tbl[6]  = '{KEY_A1, 6,  128'h6d88a37a110b3efddbf98641ca0093fd};
        tbl[7]  = '{KEY_A1, 7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
        tbl[8]  = '{KEY_A1, 8,  128'head27321b58dbad2312bf5607f8d292f};
        tbl[9]  = '{KEY_A1, 9,  128'hac7766f319fadc2128d12941575c006e};
        tbl[10] = '{KEY_A1, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        tbl[11] = '{KEY_ZERO, 0,  128'h0};
        tbl[12] = '{KEY_ZERO, 1,  128'h62636363626363636263636362636363};
        tbl[13] = '{KEY_ZERO, 10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};

        rst_n     = 1'b0;
        key_valid = 1'b0;
        key_in    = '0;
        rk_ready  = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_key_ready", {127'b0, key_ready}, 128'd1);
        chk("reset_rk_valid", {127'b0, rk_valid}, 128'd0);
        chk("reset_rk_data", rk_data, 128'd0);
        chk("reset_rk_round", {124'b0, rk_round}, 128'd0);
        chk("reset_rk_last", {127'b0, rk_last}, 128'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Full-rate stream for the FIPS-197 A.1 key.
        clear_got();
        accept_key(KEY_A1, 1'b0);
        collect(1'b0);
        compare_table(KEY_A1);

        // All-zero key.
        @(negedge clk);
        clear_got();
        accept_key(KEY_ZERO, 1'b0);
        collect(1'b0);
        compare_table(KEY_ZERO);

        // Random consumer stalls.
        @(negedge clk);
        clear_got();
        accept_key(KEY_A1, 1'b0);
        collect(1'b1);
        compare_table(KEY_A1);

        // key_valid held with a different key throughout ACTIVE.
        @(negedge clk);
        clear_got();
        accept_key(KEY_A1, 1'b1);
        key_in = KEY_ZERO;
        collect(1'b0);
        compare_table(KEY_A1);
        clear_got();
        @(negedge clk);
        collect(1'b0);
        key_valid = 1'b0;
        compare_table(KEY_ZERO);

        // Asynchronous reset in the middle of an expansion.
        @(negedge clk);
        accept_key(KEY_A1, 1'b0);
        rk_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("pre_reset_round", {124'b0, rk_round}, 128'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_rk_valid", {127'b0, rk_valid}, 128'd0);
        chk("midreset_key_ready", {127'b0, key_ready}, 128'd1);
        chk("midreset_rk_data", rk_data, 128'd0);
        chk("midreset_rk_round", {124'b0, rk_round}, 128'd0);
        chk("midreset_rk_last", {127'b0, rk_last}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_got();
        accept_key(KEY_A1, 1'b0);
        collect(1'b0);
        compare_table(KEY_A1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
